// File: rtl/alu_operand_stage.sv
// Register file plus one-entry valid/ready operand stage feeding the ALU.
// Optional: define ALU_OPERAND_REFRESH_EN to refresh stalled operands from writeback.
module alu_operand_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              InValid,
  output logic              InReady,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [DATA_W-1:0] ImmVal,
  input  logic              ALUSrc,
  input  logic [3:0]        ALUCtrlIn,
  input  logic              RegWr,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] BusW,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  output logic [3:0]        ALUCtrl
);

  localparam logic [ADDR_W-1:0] Xzr = ADDR_W'(NREGS - 1);

  // Entry NREGS-1 is never written, so it reads as zero regardless of the mux below.
  logic [DATA_W-1:0] regs_q [NREGS];

  logic              wr_en;
  logic [DATA_W-1:0] rd_a, rd_b, op_b;
  logic              accept, stall;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] bus_a_q, bus_a_d;
  logic [DATA_W-1:0] bus_b_q, bus_b_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;

  assign wr_en = RegWr && (RW != Xzr);

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[RW] <= BusW;
    end
  end

  // Same-cycle writeback is forwarded so an accepted operand never misses it.
  always_comb begin
    rd_a = regs_q[RA];
    if (RA == Xzr)                 rd_a = '0;
    else if (RegWr && (RW == RA))  rd_a = BusW;
    rd_b = regs_q[RB];
    if (RB == Xzr)                 rd_b = '0;
    else if (RegWr && (RW == RB))  rd_b = BusW;
  end

  assign op_b    = ALUSrc ? ImmVal : rd_b;
  assign InReady = !out_valid_q || OutReady;
  assign accept  = InValid && InReady;
  assign stall   = out_valid_q && !OutReady;

`ifdef ALU_OPERAND_REFRESH_EN
  logic [ADDR_W-1:0] ra_q, rb_q;
  logic              alu_src_q;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      ra_q      <= '0;
      rb_q      <= '0;
      alu_src_q <= 1'b0;
    end else if (accept) begin
      ra_q      <= RA;
      rb_q      <= RB;
      alu_src_q <= ALUSrc;
    end
  end
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    bus_a_d     = bus_a_q;
    bus_b_d     = bus_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    if (accept) begin
      out_valid_d = 1'b1;
      bus_a_d     = rd_a;
      bus_b_d     = op_b;
      alu_ctrl_d  = ALUCtrlIn;
    end else if (out_valid_q && OutReady) begin
      out_valid_d = 1'b0;
    end
`ifdef ALU_OPERAND_REFRESH_EN
    // A held operation tracks writebacks to its sources so it never goes stale.
    if (stall && wr_en) begin
      if (RW == ra_q)                bus_a_d = BusW;
      if (!alu_src_q && RW == rb_q)  bus_b_d = BusW;
    end
`else
    if (stall) begin
      bus_a_d = bus_a_q;
      bus_b_d = bus_b_q;
    end
`endif
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      out_valid_q <= 1'b0;
      bus_a_q     <= '0;
      bus_b_q     <= '0;
      alu_ctrl_q  <= 4'b0000;
    end else begin
      out_valid_q <= out_valid_d;
      bus_a_q     <= bus_a_d;
      bus_b_q     <= bus_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
    end
  end

  assign OutValid = out_valid_q;
  assign BusA     = bus_a_q;
  assign BusB     = bus_b_q;
  assign ALUCtrl  = alu_ctrl_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; expectations follow ALU_OPERAND_REFRESH_EN if defined.
module tb_alu_operand_stage;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        InValid;
  logic        InReady;
  logic [4:0]  RA, RB, RW;
  logic [63:0] ImmVal, BusW, BusA, BusB;
  logic        ALUSrc, RegWr, OutValid, OutReady;
  logic [3:0]  ALUCtrlIn, ALUCtrl;

  int checks = 0;
  int errors = 0;

  alu_operand_stage dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .InValid   (InValid),
    .InReady   (InReady),
    .RA        (RA),
    .RB        (RB),
    .ImmVal    (ImmVal),
    .ALUSrc    (ALUSrc),
    .ALUCtrlIn (ALUCtrlIn),
    .RegWr     (RegWr),
    .RW        (RW),
    .BusW      (BusW),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .BusA      (BusA),
    .BusB      (BusB),
    .ALUCtrl   (ALUCtrl)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] tp_val(input int i);
    return 64'h1000 + 64'(i) * 64'd17;
  endfunction

  initial begin
    logic [63:0] exp_a;
    Reset_L = 1'b0; InValid = 1'b0; RA = '0; RB = '0; RW = '0; ImmVal = '0; BusW = '0;
    ALUSrc = 1'b0; RegWr = 1'b0; OutReady = 1'b0; ALUCtrlIn = '0;
    tick(); tick();
    Reset_L = 1'b1;
    check("rst_outvalid", 64'(OutValid), 64'd0);
    check("rst_busa", BusA, 64'd0);
    check("rst_inready", 64'(InReady), 64'd1);

    // Write then read
    RegWr = 1'b1; RW = 5'd3; BusW = 64'h0123_4567_89AB_CDEF;
    tick();
    RegWr = 1'b0; InValid = 1'b1; RA = 5'd3; RB = 5'd31; ALUSrc = 1'b0;
    ALUCtrlIn = 4'b0010; OutReady = 1'b1;
    tick();
    InValid = 1'b0;
    check("wr_rd_busa", BusA, 64'h0123_4567_89AB_CDEF);
    check("wr_rd_busb", BusB, 64'd0);
    check("wr_rd_ctrl", 64'(ALUCtrl), 64'd2);
    check("wr_rd_valid", 64'(OutValid), 64'd1);
    tick();
    check("drain_valid", 64'(OutValid), 64'd0);
    check("drain_busa_kept", BusA, 64'h0123_4567_89AB_CDEF);

    // XZR write ignored, immediate select
    RegWr = 1'b1; RW = 5'd31; BusW = 64'hFFFF; InValid = 1'b1; RA = 5'd31;
    ALUSrc = 1'b1; ImmVal = 64'd42; ALUCtrlIn = 4'b0011;
    tick();
    check("xzr_busa", BusA, 64'd0);
    check("imm_busb", BusB, 64'd42);
    RegWr = 1'b0; RA = 5'd31; RB = 5'd31; ALUSrc = 1'b0;
    tick();
    check("xzr_read_a", BusA, 64'd0);
    check("xzr_read_b", BusB, 64'd0);

    // Same-cycle bypass on both sources
    RegWr = 1'b1; RW = 5'd7; BusW = 64'd99; RA = 5'd7; RB = 5'd7;
    tick();
    check("bypass_a", BusA, 64'd99);
    check("bypass_b", BusB, 64'd99);

    // Stall and hold
    InValid = 1'b0; RW = 5'd10; BusW = 64'd100;
    tick();
    RegWr = 1'b0; InValid = 1'b1; RA = 5'd10; RB = 5'd7; ALUCtrlIn = 4'b0101; OutReady = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      check("stall_inready", 64'(InReady), 64'd0);
      check("stall_valid", 64'(OutValid), 64'd1);
      check("stall_busa", BusA, 64'd100);
      check("stall_busb", BusB, 64'd99);
      check("stall_ctrl", 64'(ALUCtrl), 64'd5);
      tick();
    end
    RegWr = 1'b1; RW = 5'd10; BusW = 64'd5;
    tick();
    RegWr = 1'b0;
`ifdef ALU_OPERAND_REFRESH_EN
    exp_a = 64'd5;
`else
    exp_a = 64'd100;
`endif
    check("stall_wr_busa", BusA, exp_a);
    check("stall_wr_busb", BusB, 64'd99);
    InValid = 1'b0; OutReady = 1'b1;
    #1;
    check("release_inready", 64'(InReady), 64'd1);
    tick();
    check("release_valid", 64'(OutValid), 64'd0);
    check("release_busa_kept", BusA, exp_a);

    // Throughput: preload X1..X8 then stream
    for (int i = 1; i <= 8; i++) begin
      RegWr = 1'b1; RW = 5'(i); BusW = tp_val(i);
      tick();
    end
    RegWr = 1'b0; InValid = 1'b1; OutReady = 1'b1; ALUSrc = 1'b1; ImmVal = 64'd0;
    for (int i = 1; i <= 8; i++) begin
      RA = 5'(i);
      tick();
      check("tp_valid", 64'(OutValid), 64'd1);
      check("tp_busa", BusA, tp_val(i));
    end
    InValid = 1'b0;
    tick();
    check("tp_end_valid", 64'(OutValid), 64'd0);

    // Asynchronous reset mid-operation
    RegWr = 1'b1; RW = 5'd5; BusW = 64'd77;
    tick();
    RegWr = 1'b0; InValid = 1'b1; RA = 5'd5; RB = 5'd5; ALUSrc = 1'b0;
    ALUCtrlIn = 4'b1010; OutReady = 1'b0;
    tick();
    InValid = 1'b0;
    check("pre_rst_valid", 64'(OutValid), 64'd1);
    check("pre_rst_busa", BusA, 64'd77);
    #2;
    Reset_L = 1'b0;
    #1;
    check("arst_valid", 64'(OutValid), 64'd0);
    check("arst_busa", BusA, 64'd0);
    check("arst_busb", BusB, 64'd0);
    check("arst_ctrl", 64'(ALUCtrl), 64'd0);
    tick();
    Reset_L = 1'b1;
    InValid = 1'b1; OutReady = 1'b1;
    tick();
    InValid = 1'b0;
    check("post_rst_x5_a", BusA, 64'd0);
    check("post_rst_x5_b", BusB, 64'd0);
    check("post_rst_valid", 64'(OutValid), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
